mca_acq_ctrl: RTL

MCA_ACQ_CTRL -- requirements
Module: mca_acq_ctrl

---
 rtl/mca_acq_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mca_acq_ctrl.sv
// Acquisition controller for a multichannel analyser: bins pulse-height events into an
// external single-port histogram RAM (1-cycle read latency) via read-modify-write.
module mca_acq_ctrl #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned BIN_W  = 32,
    parameter int unsigned TIME_W = 32
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              cfg_start,
    input  logic              cfg_stop,
    input  logic              cfg_clear,
    input  logic              cfg_preset_en,
    input  logic [TIME_W-1:0] cfg_preset_ticks,
    input  logic              tick_in,
    input  logic              evt_strobe,
    input  logic [ADDR_W-1:0] evt_chan,
    input  logic [ADDR_W-1:0] host_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [BIN_W-1:0]  mem_wdata,
    input  logic [BIN_W-1:0]  mem_rdata,
    output logic [2:0]        state_o,
    output logic              done,
    output logic [TIME_W-1:0] live_ticks,
    output logic [BIN_W-1:0]  event_count,
    output logic [BIN_W-1:0]  dropped_count
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StClear = 3'd1,
        StAcq   = 3'd2,
        StIncRd = 3'd3,
        StIncWr = 3'd4,
        StDone  = 3'd5
    } state_e;

    localparam logic [ADDR_W-1:0] AddrLast = '1;
    localparam logic [BIN_W-1:0]  BinMax   = '1;
    localparam logic [TIME_W-1:0] TimeMax  = '1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic [ADDR_W-1:0] chan_q, chan_d;
    logic              stop_q, stop_d;
    logic [TIME_W-1:0] live_q, live_d;
    logic [BIN_W-1:0]  evt_cnt_q, evt_cnt_d;
    logic [BIN_W-1:0]  drop_q, drop_d;
    logic              start_run;
    logic              preset_hit;
    logic              in_run;
    logic              busy;

    assign preset_hit = cfg_preset_en && (live_q >= cfg_preset_ticks);
    assign in_run     = (state_q == StAcq) || (state_q == StIncRd) || (state_q == StIncWr);
    assign busy       = (state_q == StIncRd) || (state_q == StIncWr) || (state_q == StClear);

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        chan_d     = chan_q;
        stop_d     = stop_q;
        live_d     = live_q;
        evt_cnt_d  = evt_cnt_q;
        drop_d     = drop_q;
        start_run  = 1'b0;
        mem_addr   = host_addr;
        mem_we     = 1'b0;
        mem_wdata  = '0;

        case (state_q)
            StIdle, StDone: begin
                if (cfg_clear) begin
                    state_d    = StClear;
                    clr_addr_d = '0;
                end else if (cfg_start) begin
                    state_d   = StAcq;
                    start_run = 1'b1;
                end
            end
            StClear: begin
                mem_we     = 1'b1;
                mem_addr   = clr_addr_q;
                clr_addr_d = clr_addr_q + ADDR_W'(1);
                if (clr_addr_q == AddrLast) state_d = StIdle;
            end
            StAcq: begin
                // Stop/preset outranks a coincident event, which is then simply not taken.
                if (cfg_stop || stop_q || preset_hit) begin
                    state_d = StDone;
                    stop_d  = 1'b0;
                end else if (evt_strobe) begin
                    chan_d   = evt_chan;
                    mem_addr = evt_chan;
                    state_d  = StIncRd;
                end
            end
            StIncRd: begin
                mem_addr = chan_q;
                state_d  = StIncWr;
                if (cfg_stop) stop_d = 1'b1;
            end
            StIncWr: begin
                mem_addr  = chan_q;
                mem_we    = 1'b1;
                mem_wdata = (mem_rdata == BinMax) ? BinMax : mem_rdata + BIN_W'(1);
                if (evt_cnt_q != BinMax) evt_cnt_d = evt_cnt_q + BIN_W'(1);
                state_d   = StAcq;
                if (cfg_stop) stop_d = 1'b1;
            end
            default: state_d = StIdle;
        endcase

        if (tick_in && in_run && (live_q != TimeMax)) live_d = live_q + TIME_W'(1);
        if (evt_strobe && busy && (drop_q != BinMax)) drop_d = drop_q + BIN_W'(1);

        if (start_run) begin
            live_d    = '0;
            evt_cnt_d = '0;
            drop_d    = '0;
            stop_d    = 1'b0;
        end

        // RAM-facing outputs go quiet the instant reset asserts, not at the next edge.
        if (!ARESETN) begin
            mem_addr  = '0;
            mem_we    = 1'b0;
            mem_wdata = '0;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q    <= StIdle;
            clr_addr_q <= '0;
            chan_q     <= '0;
            stop_q     <= 1'b0;
            live_q     <= '0;
            evt_cnt_q  <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            chan_q     <= chan_d;
            stop_q     <= stop_d;
            live_q     <= live_d;
            evt_cnt_q  <= evt_cnt_d;
            drop_q     <= drop_d;
        end
    end

    assign state_o       = state_q;
    assign done          = (state_q == StDone);
    assign live_ticks    = live_q;
    assign event_count   = evt_cnt_q;
    assign dropped_count = drop_q;

endmodule
